// File: rtl/fp_pkg.sv
// Shared types for schedulers that front a shared floating-point unit.
package fp_pkg;

    localparam int FP_WORD_W   = 32;
    localparam int FP_ID_MAX_W = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        FLUSHED = 2'd2
    } fp_sched_state_t;

    typedef struct packed {
        logic                   valid;
        logic [FP_ID_MAX_W-1:0] id;
    } fp_tag_t;

    function automatic fp_tag_t fp_make_tag(input logic [FP_ID_MAX_W-1:0] id);
        fp_tag_t t;
        t.valid = 1'b1;
        t.id    = id;
        return t;
    endfunction

endpackage

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search begins one position after ptr (the last winner).
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);

    logic found_s;
    int   pos_s;

    // Scan all N slots in priority order and keep the first requester.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        pos_s   = 0;
        for (int i = 1; i <= N; i++) begin
            pos_s = (int'(ptr) + i) % N;
            if (!found_s && req[pos_s]) begin
                found_s      = 1'b1;
                grant[pos_s] = 1'b1;
                idx          = W'(pos_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one external add/sub unit among NUM_REQ requesters with round-robin issue and ID tagging.
// Optional issue/stall statistics ports are built when FP_SCHED_STATS_EN is defined.
module fp_add_scheduler
    import fp_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FPU_LATENCY = 1,
    parameter int ID_W        = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*FP_WORD_W-1:0]   req_a,
    input  logic [NUM_REQ*FP_WORD_W-1:0]   req_b,
    input  logic [NUM_REQ-1:0]             req_negate,
    output logic [FP_WORD_W-1:0]           fpu_a,
    output logic [FP_WORD_W-1:0]           fpu_b,
    output logic                           fpu_negate,
    input  logic [FP_WORD_W-1:0]           fpu_out,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [FP_WORD_W-1:0]           rsp_data,
    input  logic                           flush_req,
    output logic                           flush_done,
    output logic                           busy
`ifdef FP_SCHED_STATS_EN
    ,
    output logic [31:0]                    stat_issues,
    output logic [31:0]                    stat_stall
`endif
);

    localparam int DEPTH = FPU_LATENCY + 1;
    localparam int CNT_W = $clog2(DEPTH + 1) + 1;

    fp_sched_state_t     state_r;
    logic [ID_W-1:0]     ptr_r;
    logic                granted_once_r;
    logic [ID_W-1:0]     arb_ptr_s;
    logic [ID_W-1:0]     win_idx_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic                issue_s;
    logic                retire_s;
    fp_tag_t             pipe_r [DEPTH];
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_nxt_s;

    // Before the first grant the search must start at index 0, so pretend the last winner was N-1.
    assign arb_ptr_s = granted_once_r ? ptr_r : ID_W'(NUM_REQ - 1);

    rr_arbiter #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (arb_ptr_s),
        .grant (grant_s),
        .idx   (win_idx_s)
    );

    // Grants are only offered while running and out of reset.
    always_comb begin
        if (!rst && (state_r == RUN)) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    assign issue_s  = |(req_valid & req_ready);
    assign retire_s = pipe_r[DEPTH-1].valid;

    // In-flight occupancy: issue and retire on the same edge cancel out.
    always_comb begin
        case ({issue_s, retire_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Operand launch, tag pipe aligned to the adder latency, and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_a          <= '0;
            fpu_b          <= '0;
            fpu_negate     <= 1'b0;
            ptr_r          <= '0;
            granted_once_r <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                pipe_r[k] <= '0;
            end
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_data       <= '0;
            count_r        <= '0;
            busy           <= 1'b0;
        end else begin
            if (issue_s) begin
                fpu_a          <= req_a[int'(win_idx_s)*FP_WORD_W +: FP_WORD_W];
                fpu_b          <= req_b[int'(win_idx_s)*FP_WORD_W +: FP_WORD_W];
                fpu_negate     <= req_negate[win_idx_s];
                ptr_r          <= win_idx_s;
                granted_once_r <= 1'b1;
                pipe_r[0]      <= fp_make_tag(FP_ID_MAX_W'(win_idx_s));
            end else begin
                pipe_r[0]      <= '0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
            rsp_valid <= retire_s;
            if (retire_s) begin
                rsp_id   <= ID_W'(pipe_r[DEPTH-1].id);
                rsp_data <= fpu_out;
            end
            count_r <= count_nxt_s;
            busy    <= (count_nxt_s != '0);
        end
    end

    // Flush FSM: stop granting, let in-flight work retire, then report flushed until released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RUN;
            flush_done <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (flush_req) begin
                        state_r <= DRAIN;
                    end
                    flush_done <= 1'b0;
                end
                DRAIN: begin
                    if (count_r == '0) begin
                        state_r    <= FLUSHED;
                        flush_done <= 1'b1;
                    end
                end
                FLUSHED: begin
                    if (!flush_req) begin
                        state_r    <= RUN;
                        flush_done <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= RUN;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef FP_SCHED_STATS_EN
    // Issue count and contended-but-idle cycle count, both free-running with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issues <= 32'd0;
            stat_stall  <= 32'd0;
        end else begin
            if (issue_s) begin
                stat_issues <= stat_issues + 32'd1;
            end
            if ((|req_valid) && !issue_s) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler: vector table, directed flush/reset sequences and a random run against a queue-based model.
`timescale 1ns/1ps
module tb_fp_add_scheduler;

    localparam int N  = 4;
    localparam int L  = 1;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N-1:0]      req_negate;
    logic [31:0]       fpu_a, fpu_b, fpu_out;
    logic              fpu_negate;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [31:0]       rsp_data;
    logic              flush_req;
    logic              flush_done;
    logic              busy;
`ifdef FP_SCHED_STATS_EN
    logic [31:0]       stat_issues, stat_stall;
`endif

    fp_add_scheduler #(.NUM_REQ(N), .FPU_LATENCY(L), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_negate(req_negate),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_negate(fpu_negate), .fpu_out(fpu_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
`ifdef FP_SCHED_STATS_EN
        , .stat_issues(stat_issues), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // IEEE single <-> real via the double-precision encoding (normal numbers and zero only)
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b, input logic neg);
        return r2sp(neg ? (sp2r(a) - sp2r(b)) : (sp2r(a) + sp2r(b)));
    endfunction

    function automatic logic [31:0] rand_fp();
        int v;
        v = int'($urandom_range(1, 1000));
        if ($urandom_range(0, 1) == 1) v = -v;
        return r2sp($itor(v));
    endfunction

    // external adder with one register stage
    always @(posedge clk) fpu_out <= fp_add(fpu_a, fpu_b, fpu_negate);

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    typedef struct { int id; logic [31:0] data; int due; } exp_t;
    exp_t        mq[$];
    exp_t        e;
    int          m_state = 0;   // 0 running, 1 draining, 2 flushed
    int          m_last  = -1;
    logic [N-1:0] m_acc  = '0;
    logic [N-1:0] mg;
    int          m_issues = 0;
    int          m_stall  = 0;
    int          m_cnt;

    function automatic logic [N-1:0] m_grant();
        int j;
        if (rst || m_state != 0) return '0;
        for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (req_valid[j]) return N'(1) << j;
        end
        return '0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            mg = m_grant();
            check("ready", req_ready, mg);
            if (mq.size() > 0 && mq[0].due == cyc) begin
                e = mq.pop_front();
                check("rsp_valid", rsp_valid, 1);
                check("rsp_id", rsp_id, e.id);
                check("rsp_data", rsp_data, e.data);
            end else begin
                check("rsp_idle", rsp_valid, 0);
            end
            check("busy", busy, mq.size() != 0);
            check("flush_done", flush_done, m_state == 2);
`ifdef FP_SCHED_STATS_EN
            check("stat_issues", stat_issues, m_issues);
            check("stat_stall", stat_stall, m_stall);
`endif
            if (rst) begin
                mq.delete();
                m_state = 0; m_last = -1; m_acc = '0; m_issues = 0; m_stall = 0;
            end else begin
                m_cnt = mq.size();
                m_acc = mg & req_valid;
                if (m_acc != '0) begin
                    for (int j = 0; j < N; j++) begin
                        if (m_acc[j]) begin
                            e.id   = j;
                            e.data = fp_add(req_a[j*32 +: 32], req_b[j*32 +: 32], req_negate[j]);
                            e.due  = cyc + L + 2;
                            mq.push_back(e);
                            m_last = j;
                        end
                    end
                    m_issues++;
                end else if (|req_valid) begin
                    m_stall++;
                end
                case (m_state)
                    0: if (flush_req) m_state = 1;
                    1: if (m_cnt == 0) m_state = 2;
                    2: if (!flush_req) m_state = 0;
                    default: m_state = 0;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; req_valid = '0; flush_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic        neg;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vt[4];

    bit got;
    int t0;

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        vt[0] = '{2, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
        vt[1] = '{1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
        vt[2] = '{3, 32'h40A00000, 32'h40400000, 1'b1, 32'h40000000};
        vt[3] = '{0, 32'h41200000, 32'hC0800000, 1'b0, 32'h40C00000};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_negate = '0; flush_req = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_fpu_a", fpu_a, 0);
        check("rst_rsp_id", rsp_id, 0);

        // single operations from idle, one per table row
        for (int v = 0; v < 4; v++) begin
            tick();
            req_valid = N'(1) << vt[v].r;
            req_a[vt[v].r*32 +: 32] = vt[v].a;
            req_b[vt[v].r*32 +: 32] = vt[v].b;
            req_negate[vt[v].r]     = vt[v].neg;
            @(negedge clk);
            check("tbl_ready", req_ready, N'(1) << vt[v].r);
            t0 = cyc;
            tick();
            req_valid = '0;
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                if (rsp_valid) got = 1'b1;
            end
            check("tbl_rsp_seen", got, 1);
            check("tbl_latency", cyc - t0, 3);
            check("tbl_id", rsp_id, vt[v].r);
            check("tbl_data", rsp_data, vt[v].exp_data);
        end

        // all four requesting from reset: strict rotation 0,1,2,3,...
        tick();
        rst = 1'b1; req_valid = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_rotation", req_ready, N'(1) << (k % N));
            tick();
        end
        req_valid = '0;
        repeat (5) tick();

        // flush: two issues, flush rises with the second, drain, then resume at ptr+1
        do_reset();
        req_valid = 4'b1111;
        @(negedge clk);
        check("fl_first", req_ready, 4'b0001);
        tick();
        flush_req = 1'b1;
        @(negedge clk);
        check("fl_second", req_ready, 4'b0010);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            @(negedge clk);
            check("fl_no_ready", req_ready, 0);
            if (flush_done) got = 1'b1;
        end
        check("fl_reached", got, 1);
        check("fl_busy", busy, 0);
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        check("fl_hold", req_ready, 0);
        tick();
        @(negedge clk);
        check("fl_resume", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        repeat (5) tick();

        // reset one cycle after an issue discards the operation
        do_reset();
        req_valid = 4'b0001;
        @(negedge clk);
        check("rs_issue", req_ready, 4'b0001);
        tick();
        req_valid = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rs_fpu_a", fpu_a, 0);
        check("rs_fpu_b", fpu_b, 0);
        check("rs_fpu_neg", fpu_negate, 0);
        check("rs_rsp_valid", rsp_valid, 0);
        check("rs_rsp_data", rsp_data, 0);
        check("rs_busy", busy, 0);
        repeat (4) tick();

`ifdef FP_SCHED_STATS_EN
        // 10 issues then 3 contended cycles while flushed
        do_reset();
        req_valid = 4'b0001;
        repeat (10) tick();
        req_valid = '0; flush_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (flush_done) got = 1'b1;
            tick();
        end
        check("st_flushed", got, 1);
        req_valid = 4'b0001;
        repeat (3) tick();
        req_valid = '0; flush_req = 1'b0;
        @(negedge clk);
        check("st_issues10", stat_issues, 10);
        check("st_stall3", stat_stall, 3);
        repeat (3) tick();
`endif

        // random traffic with occasional flush toggling
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_acc[i]) begin
                    if ($urandom_range(0, 99) < 55) begin
                        req_valid[i]        = 1'b1;
                        req_a[i*32 +: 32]   = rand_fp();
                        req_b[i*32 +: 32]   = rand_fp();
                        req_negate[i]       = 1'(($urandom_range(0, 1)));
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            if ($urandom_range(0, 29) == 0) flush_req = ~flush_req;
        end
        tick();
        req_valid = '0; flush_req = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("final_empty", mq.size(), 0);
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
